// File: rtl/counter_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_pkg
// Description : Shared types and constants for the counter sequencer:
//               FSM state encoding, command record and the odd-counter
//               preset (start 1, step 2).
// Revision    : 1.0 - initial release
// ============================================================================
package counter_seq_pkg;

  localparam int SEQ_CNT_W = 8;
  localparam int SEQ_LEN_W = 8;

  // Odd-number counter preset: 1, 3, 5, ...
  localparam logic [SEQ_CNT_W-1:0] ODD_START = 8'd1;
  localparam logic [SEQ_CNT_W-1:0] ODD_STEP  = 8'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [SEQ_CNT_W-1:0] start;
    logic [SEQ_CNT_W-1:0] step;
    logic [SEQ_LEN_W-1:0] len;
  } seq_cmd_t;

endpackage : counter_seq_pkg
`default_nettype wire

// File: rtl/counter_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_ctrl_if
// Description : Command / status bundle between a config master and the
//               counter sequencer. With COUNTER_SEQ_PAUSE_EN defined the
//               bundle carries an extra pause_i request.
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_seq_ctrl_if #(
  parameter int CNT_W = 8,
  parameter int LEN_W = 8
);

  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [CNT_W-1:0] cmd_start_i;
  logic [CNT_W-1:0] cmd_step_i;
  logic [LEN_W-1:0] cmd_len_i;
  logic             abort_i;
  logic [CNT_W-1:0] cnt_o;
  logic             cnt_valid_o;
  logic             busy_o;
  logic             done_o;
`ifdef COUNTER_SEQ_PAUSE_EN
  logic             pause_i;
`endif

  // Config/test master: issues commands, observes the counter stream
  modport master (
`ifdef COUNTER_SEQ_PAUSE_EN
    output pause_i,
`endif
    output cmd_valid_i, cmd_start_i, cmd_step_i, cmd_len_i, abort_i,
    input  cmd_ready_o, cnt_o, cnt_valid_o, busy_o, done_o
  );

  // Sequencer side
  modport slave (
`ifdef COUNTER_SEQ_PAUSE_EN
    input  pause_i,
`endif
    input  cmd_valid_i, cmd_start_i, cmd_step_i, cmd_len_i, abort_i,
    output cmd_ready_o, cnt_o, cnt_valid_o, busy_o, done_o
  );

endinterface : counter_seq_ctrl_if
`default_nettype wire

// File: rtl/step_counter.sv
`default_nettype none
// ============================================================================
// Module      : step_counter
// Description : Registered counter value. A load takes priority over an
//               increment; the increment wraps modulo 2**CNT_W.
// Revision    : 1.0 - initial release
// ============================================================================
module step_counter #(
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             load_i,
  input  wire logic [CNT_W-1:0] load_val_i,
  input  wire logic             en_i,
  input  wire logic [CNT_W-1:0] step_i,
  output logic      [CNT_W-1:0] value_o
);

  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;

  // Next value: load, step, or hold
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (en_i) begin
      value_d = value_q + step_i;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule : step_counter
`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_ctrl
// Description : Command-driven burst sequencer for the stepping counter.
//               Accepts {start, step, len} in IDLE, emits len values one
//               per clock, pulses done_o after a normal finish, supports
//               abort. Optional feature macro: COUNTER_SEQ_PAUSE_EN adds a
//               pause_i input that freezes an active burst.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int CNT_W = SEQ_CNT_W,
  parameter int LEN_W = SEQ_LEN_W
) (
  input  wire logic        clk,
  input  wire logic        reset,
  counter_seq_ctrl_if.slave bus
);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [LEN_W-1:0] remaining_q;
  logic [LEN_W-1:0] remaining_d;
  logic [CNT_W-1:0] step_q;
  logic [CNT_W-1:0] step_d;
  logic             cnt_valid_q;
  logic             cnt_valid_d;

  logic             cmd_accept;
  logic             cnt_load;
  logic             cnt_en;
  logic             pause_req;
  logic [CNT_W-1:0] cnt_value;

`ifdef COUNTER_SEQ_PAUSE_EN
  assign pause_req = bus.pause_i;
`else
  assign pause_req = 1'b0;
`endif

  // Commands are only taken while idle; fields are sampled solely on accept
  assign cmd_accept = bus.cmd_valid_i && (state_q == IDLE);

  // Next-state, burst bookkeeping and counter control
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    step_d      = step_q;
    cnt_valid_d = 1'b0;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          step_d = bus.cmd_step_i;
          if (bus.cmd_len_i != '0) begin
            state_d     = RUN;
            cnt_load    = 1'b1;
            cnt_valid_d = 1'b1;
            remaining_d = bus.cmd_len_i - LEN_W'(1);
          end else begin
            // Empty burst: straight to the completion pulse, counter untouched
            state_d = DONE;
          end
        end
      end

      RUN: begin
        if (bus.abort_i) begin
          // Abort beats both pause and the final value; no done pulse
          state_d     = IDLE;
          remaining_d = '0;
        end else if (pause_req) begin
          // Frozen: counter and remaining hold, no valid value this cycle
          state_d = RUN;
        end else if (remaining_q != '0) begin
          cnt_en      = 1'b1;
          cnt_valid_d = 1'b1;
          remaining_d = remaining_q - LEN_W'(1);
        end else begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        remaining_d = '0;
      end
    endcase
  end

  // Controller state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      step_q      <= '0;
      cnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      step_q      <= step_d;
      cnt_valid_q <= cnt_valid_d;
    end
  end

  step_counter #(
    .CNT_W (CNT_W)
  ) u_step_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (bus.cmd_start_i),
    .en_i       (cnt_en),
    .step_i     (step_q),
    .value_o    (cnt_value)
  );

  assign bus.cmd_ready_o = (state_q == IDLE);
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.done_o      = (state_q == DONE);
  assign bus.cnt_valid_o = cnt_valid_q;
  assign bus.cnt_o       = cnt_value;

endmodule : counter_seq_ctrl
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_seq_ctrl
// Description : Self-checking bench for counter_seq_ctrl: directed vector
//               table, hand-written reset / back-to-back / pause sequences,
//               and a randomized run against a burst-schedule model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_seq_ctrl;
  import counter_seq_pkg::*;

  localparam int CNT_W = 8;
  localparam int LEN_W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  counter_seq_ctrl_if #(.CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

  counter_seq_ctrl #(
    .CNT_W (CNT_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // One directed vector: inputs driven this cycle, outputs expected this cycle
  typedef struct {
    logic       v;
    logic [7:0] s;
    logic [7:0] st;
    logic [7:0] l;
    logic       ab;
    logic [7:0] e_cnt;
    logic       e_valid;
    logic       e_busy;
    logic       e_done;
    logic       e_ready;
  } vec_t;

  // Expected observable outputs for one cycle
  typedef struct {
    logic [7:0] cnt;
    logic       valid;
    logic       busy;
    logic       done;
    logic       ready;
  } exp_t;

  function automatic vec_t mk(logic v, logic [7:0] s, logic [7:0] st, logic [7:0] l,
                              logic ab, logic [7:0] c, logic ev, logic eb,
                              logic ed, logic er);
    vec_t r;
    r.v = v; r.s = s; r.st = st; r.l = l; r.ab = ab;
    r.e_cnt = c; r.e_valid = ev; r.e_busy = eb; r.e_done = ed; r.e_ready = er;
    return r;
  endfunction

  function automatic exp_t mkexp(logic [7:0] c, logic v, logic b, logic d, logic r);
    exp_t e;
    e.cnt = c; e.valid = v; e.busy = b; e.done = d; e.ready = r;
    return e;
  endfunction

  task automatic check(input string name, input logic [7:0] e_cnt, input logic e_valid,
                       input logic e_busy, input logic e_done, input logic e_ready);
    vectors++;
    if (bus.cnt_o !== e_cnt || bus.cnt_valid_o !== e_valid || bus.busy_o !== e_busy ||
        bus.done_o !== e_done || bus.cmd_ready_o !== e_ready) begin
      miscompares++;
      $display("FAIL %s @%0t: got cnt=%0d valid=%b busy=%b done=%b ready=%b, want cnt=%0d valid=%b busy=%b done=%b ready=%b",
               name, $time, bus.cnt_o, bus.cnt_valid_o, bus.busy_o, bus.done_o,
               bus.cmd_ready_o, e_cnt, e_valid, e_busy, e_done, e_ready);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] s, input logic [7:0] st,
                       input logic [7:0] l, input logic ab);
    bus.cmd_valid_i = v;
    bus.cmd_start_i = s;
    bus.cmd_step_i  = st;
    bus.cmd_len_i   = l;
    bus.abort_i     = ab;
  endtask

  // Watchdog: the test is fixed-length, so this only fires on a broken run
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[$];
    exp_t       q[$];
    exp_t       e;
    seq_cmd_t   c;
    logic [7:0] hold;
    logic [7:0] val;
    logic       rv;
    logic       rab;
    int         tmp;

    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
`ifdef COUNTER_SEQ_PAUSE_EN
    bus.pause_i = 1'b0;
`endif

    // ---------------- reset state ----------------
    @(negedge clk);
    check("reset_state", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;

    // ---------------- directed table ----------------
    // Odd burst 1,3,5
    tbl.push_back(mk(1, ODD_START, ODD_STEP, 8'd3, 0,   8'd0,   0, 0, 0, 1));
    tbl.push_back(mk(0, 8'd0, 8'd0, 8'd0, 0,            8'd1,   1, 1, 0, 0));
    tbl.push_back(mk(0, 8'd0, 8'd0, 8'd0, 0,            8'd3,   1, 1, 0, 0));
    tbl.push_back(mk(0, 8'd0, 8'd0, 8'd0, 0,            8'd5,   1, 1, 0, 0));
    tbl.push_back(mk(0, 8'd0, 8'd0, 8'd0, 0,            8'd5,   0, 1, 1, 0));
    // Wrap 250,254,2
    tbl.push_back(mk(1, 8'd250, 8'd4, 8'd3, 0,          8'd5,   0, 0, 0, 1));
    tbl.push_back(mk(0, 8'd0, 8'd0, 8'd0, 0,            8'd250, 1, 1, 0, 0));
    tbl.push_back(mk(0, 8'd0, 8'd0, 8'd0, 0,            8'd254, 1, 1, 0, 0));
    tbl.push_back(mk(0, 8'd0, 8'd0, 8'd0, 0,            8'd2,   1, 1, 0, 0));
    tbl.push_back(mk(0, 8'd0, 8'd0, 8'd0, 0,            8'd2,   0, 1, 1, 0));
    // len=0: done pulse only, counter unchanged
    tbl.push_back(mk(1, 8'd77, 8'd9, 8'd0, 0,           8'd2,   0, 0, 0, 1));
    tbl.push_back(mk(0, 8'd0, 8'd0, 8'd0, 0,            8'd2,   0, 1, 1, 0));
    // Abort on second value of 0,1,2,3,4
    tbl.push_back(mk(1, 8'd0, 8'd1, 8'd5, 0,            8'd2,   0, 0, 0, 1));
    tbl.push_back(mk(0, 8'd0, 8'd0, 8'd0, 0,            8'd0,   1, 1, 0, 0));
    tbl.push_back(mk(0, 8'd0, 8'd0, 8'd0, 1,            8'd1,   1, 1, 0, 0));
    // Abort while idle is ignored
    tbl.push_back(mk(0, 8'd0, 8'd0, 8'd0, 1,            8'd1,   0, 0, 0, 1));
    tbl.push_back(mk(0, 8'd0, 8'd0, 8'd0, 0,            8'd1,   0, 0, 0, 1));
    tbl.push_back(mk(0, 8'd0, 8'd0, 8'd0, 0,            8'd1,   0, 0, 0, 1));

    foreach (tbl[i]) begin
      @(negedge clk);
      check($sformatf("table[%0d]", i), tbl[i].e_cnt, tbl[i].e_valid, tbl[i].e_busy,
            tbl[i].e_done, tbl[i].e_ready);
      drive(tbl[i].v, tbl[i].s, tbl[i].st, tbl[i].l, tbl[i].ab);
    end

    // ---------------- reset mid-RUN ----------------
    @(negedge clk);
    drive(1'b1, 8'd100, 8'd3, 8'd10, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    check("rst_run_v0", 8'd100, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_run_v1", 8'd103, 1'b1, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 check("rst_async", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("rst_held", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_release", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // ---------------- back-to-back, cmd_valid held ----------------
    drive(1'b1, 8'd10, 8'd1, 8'd2, 1'b0);
    @(negedge clk);
    check("b2b_a0", 8'd10, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b_a1", 8'd11, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b_adone", 8'd11, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("b2b_idle", 8'd11, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("b2b_b0", 8'd10, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    @(negedge clk);
    check("b2b_b1", 8'd11, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b_bdone", 8'd11, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("b2b_end", 8'd11, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef COUNTER_SEQ_PAUSE_EN
    // ---------------- pause: 1,3,<hold>,<hold>,5 ----------------
    drive(1'b1, 8'd1, 8'd2, 8'd3, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    check("pause_v1", 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("pause_v3", 8'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.pause_i = 1'b1;
    @(negedge clk);
    check("pause_h0", 8'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("pause_h1", 8'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.pause_i = 1'b0;
    @(negedge clk);
    check("pause_v5", 8'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("pause_done", 8'd5, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("pause_idle", 8'd5, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // ---------------- randomized run vs burst-schedule model ----------------
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hold = 8'd0;
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (q.size() != 0) e = q[0];
      else               e = mkexp(hold, 1'b0, 1'b0, 1'b0, 1'b1);
      check("random", e.cnt, e.valid, e.busy, e.done, e.ready);

      rv      = ($urandom_range(0, 2) == 0);
      rab     = ($urandom_range(0, 14) == 0);
      c.start = 8'($urandom);
      c.step  = 8'($urandom);
      if ($urandom_range(0, 19) == 0) c.len = 8'($urandom_range(0, 255));
      else                            c.len = 8'($urandom_range(0, 9));
      drive(rv, c.start, c.step, c.len, rab);

      // What the upcoming clock edge does to the expected schedule
      if (q.size() != 0) begin
        hold = e.cnt;
        void'(q.pop_front());
        if (rab && e.valid) q.delete();
      end else if (rv) begin
        if (c.len == 8'd0) begin
          q.push_back(mkexp(hold, 1'b0, 1'b1, 1'b1, 1'b0));
        end else begin
          val = hold;
          for (int k = 0; k < int'(c.len); k++) begin
            tmp = int'(c.start) + k * int'(c.step);
            val = tmp[7:0];
            q.push_back(mkexp(val, 1'b1, 1'b1, 1'b0, 1'b0));
          end
          q.push_back(mkexp(val, 1'b0, 1'b1, 1'b1, 1'b0));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_counter_seq_ctrl
`default_nettype wire
